// File: rtl/bicubic_pkg.sv
// Shared constants and helpers for the bicubic streaming core and its MAC.
package bicubic_pkg;

  localparam int TAPS = 4;

  // Signed accumulator width for a 4-tap sum of zero-extended pixels times signed weights.
  function automatic int acc_w(input int data_width, input int coef_width);
    return data_width + coef_width + 2;
  endfunction

  // Half-LSB constant added before the arithmetic right shift (round to nearest, half up).
  function automatic int round_const(input int frac_bits);
    return (frac_bits > 0) ? (1 << (frac_bits - 1)) : 0;
  endfunction

  // LSB of row r, channel c inside a packed column bus.
  function automatic int col_lsb(input int r, input int c, input int channels, input int data_width);
    return (r * channels + c) * data_width;
  endfunction

  // LSB of tap k inside a packed weight bus.
  function automatic int coef_lsb(input int k, input int coef_width);
    return k * coef_width;
  endfunction

  // LSB of channel c (or tap c of a pixel vector) inside a packed pixel bus.
  function automatic int pix_lsb(input int c, input int data_width);
    return c * data_width;
  endfunction

endpackage

// File: rtl/bicubic_mac4.sv
// Combinational 4-tap signed MAC: sum(w[k]*pix[k]), round to nearest, clamp to pixel range.
module bicubic_mac4
  import bicubic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 9,
  parameter int FRAC_BITS  = 7
) (
  input  logic [TAPS*DATA_WIDTH-1:0] pix,
  input  logic [TAPS*COEF_WIDTH-1:0] w,
  output logic [DATA_WIDTH-1:0]      res
);

  localparam int AW = acc_w(DATA_WIDTH, COEF_WIDTH);
  localparam logic signed [AW-1:0] RND  = AW'(round_const(FRAC_BITS));
  localparam logic signed [AW-1:0] MAXV = AW'((2 ** DATA_WIDTH) - 1);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] scaled;

  // Accumulate taps starting from the rounding constant, then shift and clamp.
  always_comb begin
    acc = RND;
    for (int k = 0; k < TAPS; k++) begin
      acc = acc + AW'(signed'(w[coef_lsb(k, COEF_WIDTH) +: COEF_WIDTH]))
                * AW'(signed'({1'b0, pix[pix_lsb(k, DATA_WIDTH) +: DATA_WIDTH]}));
    end
    scaled = acc >>> FRAC_BITS;
    if (scaled[AW-1])
      res = '0;
    else if (scaled > MAXV)
      res = '1;
    else
      res = scaled[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/bicubic_stream_core.sv
// Multi-channel bicubic core: 4x4 window per channel, horizontal pass into stage 1,
// vertical pass into the output register, valid/ready with full-pipeline stall.
module bicubic_stream_core
  import bicubic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int COEF_WIDTH = 9,
  parameter int FRAC_BITS  = 7
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_push,
  input  logic                                in_emit,
  input  logic [TAPS*CHANNELS*DATA_WIDTH-1:0] col_in,
  input  logic [TAPS*COEF_WIDTH-1:0]          h_w,
  input  logic [TAPS*COEF_WIDTH-1:0]          v_w,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]      pixel_out,
  output logic [2:0]                          fill_level,
  output logic                                underrun
);

  localparam int COL_W = TAPS * CHANNELS * DATA_WIDTH;
  localparam int PIX_W = CHANNELS * DATA_WIDTH;
  localparam logic [2:0] FULL = 3'(TAPS);

  // col_q[0] is the newest column (c0), col_q[3] the oldest (c3).
  logic [COL_W-1:0]           col_q   [TAPS];
  logic [COL_W-1:0]           col_nxt [TAPS];
  logic [2:0]                 fill_nxt;
  logic                       advance;
  logic                       accept;
  logic                       do_push;
  logic                       do_emit;
  logic                       emit_ok;
  logic [COL_W-1:0]           h_res;
  logic                       s1_valid;
  logic [COL_W-1:0]           s1_rows;
  logic [TAPS*COEF_WIDTH-1:0] s1_vw;
  logic [PIX_W-1:0]           v_res;

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance & !clear;
  assign accept   = in_valid & in_ready;
  assign do_push  = accept & in_push;
  assign do_emit  = accept & in_emit;
  assign emit_ok  = do_emit & (fill_nxt == FULL);

  // Post-push window and fill count; emits always see these values.
  always_comb begin
    for (int i = 0; i < TAPS; i++) col_nxt[i] = col_q[i];
    fill_nxt = fill_level;
    if (do_push) begin
      col_nxt[0] = col_in;
      for (int i = 1; i < TAPS; i++) col_nxt[i] = col_q[i-1];
      if (fill_level != FULL) fill_nxt = fill_level + 3'd1;
    end
  end

  // Horizontal pass: oldest column meets w0, newest meets w3.
  for (genvar r = 0; r < TAPS; r++) begin : g_hrow
    for (genvar c = 0; c < CHANNELS; c++) begin : g_hch
      localparam int LSB = col_lsb(r, c, CHANNELS, DATA_WIDTH);
      logic [TAPS*DATA_WIDTH-1:0] taps;
      assign taps = {col_nxt[0][LSB +: DATA_WIDTH], col_nxt[1][LSB +: DATA_WIDTH],
                     col_nxt[2][LSB +: DATA_WIDTH], col_nxt[3][LSB +: DATA_WIDTH]};
      bicubic_mac4 #(
        .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH), .FRAC_BITS(FRAC_BITS)
      ) u_hmac (
        .pix(taps), .w(h_w), .res(h_res[LSB +: DATA_WIDTH])
      );
    end
  end

  // Vertical pass: row r meets v_w tap r.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_vch
    logic [TAPS*DATA_WIDTH-1:0] taps;
    assign taps = {s1_rows[col_lsb(3, c, CHANNELS, DATA_WIDTH) +: DATA_WIDTH],
                   s1_rows[col_lsb(2, c, CHANNELS, DATA_WIDTH) +: DATA_WIDTH],
                   s1_rows[col_lsb(1, c, CHANNELS, DATA_WIDTH) +: DATA_WIDTH],
                   s1_rows[col_lsb(0, c, CHANNELS, DATA_WIDTH) +: DATA_WIDTH]};
    bicubic_mac4 #(
      .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH), .FRAC_BITS(FRAC_BITS)
    ) u_vmac (
      .pix(taps), .w(s1_vw), .res(v_res[pix_lsb(c, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  // Window, fill count and sticky underrun; clear wins over any beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) col_q[i] <= '0;
      fill_level <= '0;
      underrun   <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) col_q[i] <= '0;
      fill_level <= '0;
      underrun   <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) col_q[i] <= col_nxt[i];
      fill_level <= fill_nxt;
      if (do_emit && !emit_ok) underrun <= 1'b1;
    end
  end

  // Stage 1: horizontal results plus the vertical weights that travel with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_rows  <= '0;
      s1_vw    <= '0;
    end else if (advance) begin
      s1_valid <= emit_ok;
      if (emit_ok) begin
        s1_rows <= h_res;
        s1_vw   <= v_w;
      end
    end
  end

  // Output register: holds while stalled, refills when the pipeline advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) pixel_out <= v_res;
    end
  end

endmodule
